// File: rtl/vec_mac_pkg.sv
// Shared types for the vector multiply-add issue path: op codes, SEW encodings
// and sequencer states.
package vec_mac_pkg;

   localparam int VLEN_DEF = 128;

   typedef enum logic [2:0] {
      VMACC_VV  = 3'b000,
      VMACC_VX  = 3'b001,
      VNMSAC_VV = 3'b010,
      VNMSAC_VX = 3'b011,
      VMADD_VV  = 3'b100,
      VMADD_VX  = 3'b101,
      VNMSUB_VV = 3'b110,
      VNMSUB_VX = 3'b111
   } accum_op_e;

   typedef enum logic [1:0] {
      SEW8    = 2'b00,
      SEW16   = 2'b01,
      SEW32   = 2'b10,
      SEW_ILL = 2'b11
   } sew_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      DRIVE = 2'b01,
      WAIT  = 2'b10,
      WB    = 2'b11
   } seq_state_e;

   // bit0 of the op selects the scalar (.vx) form of operand A
   function automatic logic op_is_vx(input logic [2:0] op);
      return op[0];
   endfunction

   // bit1 marks the negated-product forms (VNMSAC / VNMSUB)
   function automatic logic op_is_neg(input logic [2:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/vec_scalar_broadcast.sv
// Replicates a scalar across a VLEN-wide vector at the given element width.
// Purely combinational; the illegal SEW code yields zero.
module vec_scalar_broadcast
   import vec_mac_pkg::*;
#(
   parameter int VLEN = VLEN_DEF
) (
   input  logic [31:0]     rs1_i,
   input  logic [1:0]      sew_i,
   output logic [VLEN-1:0] bcast_o
);

   logic [VLEN-1:0] b8, b16, b32;

   genvar gi;
   generate
      for (gi = 0; gi < VLEN/8; gi++) begin : g_b8
         assign b8[gi*8 +: 8] = rs1_i[7:0];
      end
      for (gi = 0; gi < VLEN/16; gi++) begin : g_b16
         assign b16[gi*16 +: 16] = rs1_i[15:0];
      end
      for (gi = 0; gi < VLEN/32; gi++) begin : g_b32
         assign b32[gi*32 +: 32] = rs1_i;
      end
   endgenerate

   always_comb begin
      bcast_o = '0;
      case (sew_i)
         SEW8:    bcast_o = b8;
         SEW16:   bcast_o = b16;
         SEW32:   bcast_o = b32;
         default: bcast_o = '0;
      endcase
   end

endmodule

// File: rtl/vector_mac_sequencer.sv
// Issue/control stage in front of the vector multiply-add unit: latches one
// instruction, holds MAC inputs until done, then offers the result for write-back.
module vector_mac_sequencer
   import vec_mac_pkg::*;
#(
   parameter int VLEN           = VLEN_DEF,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int ADDR_W         = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [2:0]        issue_op,
   input  logic [1:0]        issue_sew,
   input  logic              issue_signed,
   input  logic [ADDR_W-1:0] issue_vd_addr,
   input  logic [VLEN-1:0]   vs1_data,
   input  logic [VLEN-1:0]   vs2_data,
   input  logic [VLEN-1:0]   vd_data,
   input  logic [31:0]       rs1_data,
   output logic [VLEN-1:0]   mac_data_A,
   output logic [VLEN-1:0]   mac_data_B,
   output logic [VLEN-1:0]   mac_data_C,
   output logic [2:0]        mac_accum_op,
   output logic [1:0]        mac_sew,
   output logic              mac_signed_mode,
   output logic              mac_ctrl,
   output logic              mac_sew_16_32,
   output logic              mac_sew_32,
   input  logic [VLEN-1:0]   mac_result,
   input  logic              mac_done,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [VLEN-1:0]   wb_data,
   output logic [ADDR_W-1:0] wb_vd_addr,
   output logic              wb_error,
   output logic              busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   seq_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [VLEN-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
   logic [2:0]        op_q, op_d;
   logic [1:0]        sew_q, sew_d;
   logic              sgn_q, sgn_d;
   logic [ADDR_W-1:0] vd_q, vd_d;
   logic [VLEN-1:0]   wbd_q, wbd_d;
   logic              err_q, err_d;
   logic [VLEN-1:0]   rs1_bcast;

   vec_scalar_broadcast #(.VLEN(VLEN)) u_bcast (
      .rs1_i   (rs1_data),
      .sew_i   (issue_sew),
      .bcast_o (rs1_bcast)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      op_d    = op_q;
      sew_d   = sew_q;
      sgn_d   = sgn_q;
      vd_d    = vd_q;
      wbd_d   = wbd_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (issue_valid) begin
               vd_d  = issue_vd_addr;
               wbd_d = '0;
               err_d = 1'b0;
               // An illegal SEW never reaches the MAC: its inputs stay at zero.
               if (issue_sew == SEW_ILL) begin
                  err_d   = 1'b1;
                  state_d = WB;
               end else begin
                  a_d     = op_is_vx(issue_op) ? rs1_bcast : vs1_data;
                  b_d     = vs2_data;
                  c_d     = vd_data;
                  op_d    = issue_op;
                  sew_d   = issue_sew;
                  sgn_d   = issue_signed;
                  state_d = DRIVE;
               end
            end
         end
         DRIVE: begin
            // done may still be high from the previous op; it is not looked at here
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mac_done) begin
               wbd_d   = mac_result;
               err_d   = 1'b0;
               state_d = WB;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               wbd_d   = '0;
               err_d   = 1'b1;
               state_d = WB;
            end
         end
         WB: begin
            if (wb_ready) begin
               a_d     = '0;
               b_d     = '0;
               c_d     = '0;
               op_d    = '0;
               sew_d   = '0;
               sgn_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         op_q    <= '0;
         sew_q   <= '0;
         sgn_q   <= 1'b0;
         vd_q    <= '0;
         wbd_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         op_q    <= op_d;
         sew_q   <= sew_d;
         sgn_q   <= sgn_d;
         vd_q    <= vd_d;
         wbd_q   <= wbd_d;
         err_q   <= err_d;
      end
   end

   assign issue_ready     = (state_q == IDLE);
   assign busy            = (state_q != IDLE);
   assign wb_valid        = (state_q == WB);
   assign wb_data         = wbd_q;
   assign wb_vd_addr      = vd_q;
   assign wb_error        = err_q;
   assign mac_data_A      = a_q;
   assign mac_data_B      = b_q;
   assign mac_data_C      = c_q;
   assign mac_accum_op    = op_q;
   assign mac_sew         = sew_q;
   assign mac_signed_mode = sgn_q;
   assign mac_ctrl        = op_is_neg(op_q);
   assign mac_sew_16_32   = (sew_q != SEW8);
   assign mac_sew_32      = (sew_q == SEW32);

endmodule

// File: tb/tb_vector_mac_sequencer.sv
// Directed bench for vector_mac_sequencer; expected write-backs are queued at
// issue time and compared when the sequencer offers them.
module tb_vector_mac_sequencer;

   localparam int VLEN = 128;
   localparam int T    = 64;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic            issue_valid, issue_ready, issue_signed;
   logic [2:0]      issue_op;
   logic [1:0]      issue_sew;
   logic [AW-1:0]   issue_vd_addr;
   logic [VLEN-1:0] vs1_data, vs2_data, vd_data;
   logic [31:0]     rs1_data;
   logic [VLEN-1:0] mac_data_A, mac_data_B, mac_data_C, mac_result;
   logic [2:0]      mac_accum_op;
   logic [1:0]      mac_sew;
   logic            mac_signed_mode, mac_ctrl, mac_sew_16_32, mac_sew_32, mac_done;
   logic            wb_valid, wb_ready, wb_error, busy;
   logic [VLEN-1:0] wb_data;
   logic [AW-1:0]   wb_vd_addr;

   vector_mac_sequencer #(.VLEN(VLEN), .TIMEOUT_CYCLES(T), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
      .issue_sew(issue_sew), .issue_signed(issue_signed), .issue_vd_addr(issue_vd_addr),
      .vs1_data(vs1_data), .vs2_data(vs2_data), .vd_data(vd_data), .rs1_data(rs1_data),
      .mac_data_A(mac_data_A), .mac_data_B(mac_data_B), .mac_data_C(mac_data_C),
      .mac_accum_op(mac_accum_op), .mac_sew(mac_sew), .mac_signed_mode(mac_signed_mode),
      .mac_ctrl(mac_ctrl), .mac_sew_16_32(mac_sew_16_32), .mac_sew_32(mac_sew_32),
      .mac_result(mac_result), .mac_done(mac_done),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
      .wb_vd_addr(wb_vd_addr), .wb_error(wb_error), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [VLEN-1:0] data;
      logic [AW-1:0]   addr;
      logic            err;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [VLEN-1:0] rnd_vec();
      logic [VLEN-1:0] v;
      for (int i = 0; i < VLEN/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // reference for 8-bit lanes: a*b+c, truncated per lane
   function automatic logic [VLEN-1:0] mac8(input logic [VLEN-1:0] a, b, c);
      logic [VLEN-1:0] r;
      for (int i = 0; i < VLEN/8; i++) r[i*8 +: 8] = a[i*8 +: 8] * b[i*8 +: 8] + c[i*8 +: 8];
      return r;
   endfunction

   task automatic issue(input logic [2:0] op, input logic [1:0] sew, input logic sgn,
                        input logic [AW-1:0] vd, input logic [VLEN-1:0] v1, v2, vo,
                        input logic [31:0] rs);
      int n;
      n = 0;
      issue_valid = 1'b1; issue_op = op; issue_sew = sew; issue_signed = sgn;
      issue_vd_addr = vd; vs1_data = v1; vs2_data = v2; vd_data = vo; rs1_data = rs;
      while (!issue_ready && n < 20) begin tick(); n++; end
      chk("issue_ready", {127'd0, issue_ready}, 1);
      tick();
      issue_valid = 1'b0;
   endtask

   task automatic take_wb(input string tag);
      int   n;
      exp_t e;
      n = 0;
      while (!wb_valid && n < T + 10) begin tick(); n++; end
      chk({tag, "_valid"}, {127'd0, wb_valid}, 1);
      checks++;
      assert (sb.size() > 0) else begin
         errors++;
         $error("FAIL %s_sb: observed empty queue expected pending entry", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_data"}, wb_data, e.data);
         chk({tag, "_addr"}, {{(VLEN-AW){1'b0}}, wb_vd_addr}, {{(VLEN-AW){1'b0}}, e.addr});
         chk({tag, "_err"}, {127'd0, wb_error}, {127'd0, e.err});
      end
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      chk({tag, "_drop"}, {127'd0, wb_valid}, 0);
      chk({tag, "_idle"}, {127'd0, issue_ready}, 1);
   endtask

   initial begin
      logic [VLEN-1:0] v1, v2, vo, ex, r;
      int n;
      reset = 1'b0; issue_valid = 1'b0; issue_op = '0; issue_sew = '0; issue_signed = 1'b0;
      issue_vd_addr = '0; vs1_data = '0; vs2_data = '0; vd_data = '0; rs1_data = '0;
      mac_result = '0; mac_done = 1'b0; wb_ready = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      chk("rst_wb_valid", {127'd0, wb_valid}, 0);
      chk("rst_busy", {127'd0, busy}, 0);
      chk("rst_issue_ready", {127'd0, issue_ready}, 1);
      chk("rst_mac_A", mac_data_A, '0);
      chk("rst_wb_data", wb_data, '0);

      // VMACC_VV, 8-bit lanes, done after 4 WAIT cycles
      v1 = {16{8'd3}}; v2 = {16{8'd4}}; vo = {16{8'd5}};
      ex = mac8(v1, v2, vo);
      sb.push_back('{{16{8'd17}}, 5'd3, 1'b0});
      issue(3'b000, 2'b00, 1'b0, 5'd3, v1, v2, vo, 32'h0);
      chk("t1_busy", {127'd0, busy}, 1);
      chk("t1_A", mac_data_A, v1);
      chk("t1_B", mac_data_B, v2);
      chk("t1_C", mac_data_C, vo);
      chk("t1_ctrl", {127'd0, mac_ctrl}, 0);
      tick();
      repeat (3) tick();
      chk("t1_no_early_wb", {127'd0, wb_valid}, 0);
      mac_done = 1'b1; mac_result = ex;
      tick();
      chk("t1_wb_next_cycle", {127'd0, wb_valid}, 1);
      mac_done = 1'b0; mac_result = '0;
      take_wb("t1");

      // VNMSUB_VX, 32-bit broadcast, stale done during DRIVE
      r = rnd_vec(); v2 = rnd_vec(); vo = rnd_vec();
      sb.push_back('{r, 5'd7, 1'b0});
      mac_done = 1'b1; mac_result = r;
      issue(3'b111, 2'b10, 1'b1, 5'd7, '0, v2, vo, 32'h0000_0002);
      chk("t2_A_bcast", mac_data_A, {4{32'h0000_0002}});
      chk("t2_ctrl", {127'd0, mac_ctrl}, 1);
      chk("t2_sew32", {127'd0, mac_sew_32}, 1);
      chk("t2_sew16_32", {127'd0, mac_sew_16_32}, 1);
      chk("t2_op", {125'd0, mac_accum_op}, {125'd0, 3'b111});
      chk("t2_signed", {127'd0, mac_signed_mode}, 1);
      tick();
      chk("t2_stale_done_ignored", {127'd0, wb_valid}, 0);
      tick();
      mac_done = 1'b0;
      take_wb("t3pre_t2");

      // illegal SEW: straight to write-back with error
      sb.push_back('{'0, 5'd9, 1'b1});
      issue(3'b100, 2'b11, 1'b0, 5'd9, rnd_vec(), rnd_vec(), rnd_vec(), 32'h0);
      chk("t3_fast_valid", {127'd0, wb_valid}, 1);
      chk("t3_no_drive_A", mac_data_A, '0);
      chk("t3_no_drive_sew", {126'd0, mac_sew}, '0);
      take_wb("t3");

      // timeout with done held low
      sb.push_back('{'0, 5'd10, 1'b1});
      issue(3'b000, 2'b01, 1'b0, 5'd10, rnd_vec(), rnd_vec(), rnd_vec(), 32'h0);
      tick();
      n = 0;
      while (!wb_valid && n < T + 10) begin tick(); n++; end
      chk("t4_timeout_cycles", VLEN'(n), VLEN'(T));
      take_wb("t4");

      // done in the last timeout cycle wins over the timeout
      r = rnd_vec();
      sb.push_back('{r, 5'd11, 1'b0});
      issue(3'b010, 2'b00, 1'b0, 5'd11, rnd_vec(), rnd_vec(), rnd_vec(), 32'h0);
      tick();
      repeat (T - 1) tick();
      chk("t4b_still_waiting", {127'd0, wb_valid}, 0);
      mac_done = 1'b1; mac_result = r;
      tick();
      mac_done = 1'b0;
      take_wb("t4b");

      // write-back back-pressure, 16-bit broadcast, ignored issue
      r = rnd_vec();
      sb.push_back('{r, 5'd12, 1'b0});
      issue(3'b001, 2'b01, 1'b0, 5'd12, '0, rnd_vec(), rnd_vec(), 32'h1234_ABCD);
      chk("t5_A_bcast16", mac_data_A, {8{16'hABCD}});
      tick();
      mac_done = 1'b1; mac_result = r;
      tick();
      mac_done = 1'b0; mac_result = rnd_vec();
      issue_valid = 1'b1; issue_op = 3'b000; issue_sew = 2'b00; issue_vd_addr = 5'd20;
      for (int i = 0; i < 5; i++) begin
         chk("t5_hold_valid", {127'd0, wb_valid}, 1);
         chk("t5_hold_data", wb_data, r);
         chk("t5_hold_addr", {123'd0, wb_vd_addr}, {123'd0, 5'd12});
         chk("t5_no_issue", {127'd0, issue_ready}, 0);
         tick();
      end
      issue_valid = 1'b0;
      take_wb("t5");
      chk("t5_not_busy", {127'd0, busy}, 0);
      r = rnd_vec();
      sb.push_back('{r, 5'd21, 1'b0});
      issue(3'b100, 2'b10, 1'b1, 5'd21, rnd_vec(), rnd_vec(), rnd_vec(), 32'h0);
      tick();
      mac_done = 1'b1; mac_result = r;
      tick();
      mac_done = 1'b0;
      take_wb("t5b");

      // reset during WAIT discards the op
      issue(3'b000, 2'b00, 1'b0, 5'd13, rnd_vec(), rnd_vec(), rnd_vec(), 32'h0);
      tick(); tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("t6_busy", {127'd0, busy}, 0);
      chk("t6_wb_valid", {127'd0, wb_valid}, 0);
      chk("t6_A", mac_data_A, '0);
      chk("t6_C", mac_data_C, '0);
      chk("t6_op", {125'd0, mac_accum_op}, '0);
      chk("t6_ready", {127'd0, issue_ready}, 1);
      mac_done = 1'b1; mac_result = rnd_vec();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t6_no_wb", {127'd0, wb_valid}, 0);
      end
      mac_done = 1'b0;
      chk("sb_drained", VLEN'(sb.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
